// File: rtl/stim_stream_driver.sv
// Stream stimulus driver: fetches samples from a sync-read memory into a 2-entry FWFT source port,
// shapes source gaps and sink back-pressure, and counts/checksums sink writes.
module stim_stream_driver #(
    parameter int DWIDTH    = 16,
    parameter int AWIDTH    = 15,
    parameter int OUT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic [AWIDTH:0]      len,
    input  logic                 loop,
    input  logic [7:0]           gap_period,
    input  logic [7:0]           gap_len,
    input  logic [7:0]           full_period,
    input  logic [7:0]           full_len,
    output logic                 mem_rden,
    output logic [AWIDTH-1:0]    mem_addr,
    input  logic [DWIDTH-1:0]    mem_data,
    output logic                 src_fifo_empty,
    input  logic                 src_fifo_rden,
    output logic [OUT_WIDTH-1:0] src_fifo_data,
    output logic                 sink_fifo_full,
    input  logic                 sink_fifo_wren,
    input  logic [OUT_WIDTH-1:0] sink_fifo_data,
    output logic                 busy,
    output logic                 done,
    output logic [31:0]          words_sent,
    output logic [31:0]          words_recv,
    output logic [31:0]          sink_checksum,
    output logic [1:0]           err
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [AWIDTH-1:0] ADDR_ONE = 1;
    localparam logic [AWIDTH:0]   CNT_ONE  = 1;

    function automatic logic [7:0] clamp_len(input logic [7:0] period, input logic [7:0] plen);
        if (period == 8'd0) return 8'd0;
        if (plen >= period) return period - 8'd1;
        return plen;
    endfunction

    function automatic logic phase_active(input logic [7:0] phase, input logic [7:0] period,
                                          input logic [7:0] eff_len);
        return (eff_len != 8'd0) && (phase >= period - eff_len);
    endfunction

    function automatic logic [7:0] next_phase(input logic [7:0] phase, input logic [7:0] period);
        if (period == 8'd0) return 8'd0;
        return (phase == period - 8'd1) ? 8'd0 : phase + 8'd1;
    endfunction

    function automatic logic [31:0] rotl_xor(input logic [31:0] sum, input logic [31:0] word);
        return {sum[30:0], sum[31]} ^ word;
    endfunction

    state_t            state;
    logic [AWIDTH:0]   len_q;
    logic              loop_q;
    logic [7:0]        gap_period_q, gap_len_q, full_period_q, full_len_q;
    logic [7:0]        gap_phase, full_phase;
    logic [AWIDTH:0]   fetched;
    logic              rd_vld_p1;
    logic [1:0]        occ;
    logic              wr_ptr, rd_ptr;
    logic [DWIDTH-1:0] fifo_buf [2];

    logic run, gap_active, full_active, pop, wr_acc, budget_ok, addr_wrap;

    assign run         = (state == RUN);
    assign busy        = run;
    assign done        = (state == DONE);
    assign gap_active  = phase_active(gap_phase, gap_period_q, gap_len_q);
    assign full_active = phase_active(full_phase, full_period_q, full_len_q);

    assign src_fifo_empty = !run || (occ == 2'd0) || gap_active;
    assign src_fifo_data  = (occ != 2'd0) ? OUT_WIDTH'(fifo_buf[rd_ptr]) : '0;
    assign pop            = src_fifo_rden && !src_fifo_empty;

    assign sink_fifo_full = run && full_active;
    assign wr_acc         = sink_fifo_wren && !sink_fifo_full;

    // A pop in the same cycle frees a slot, which keeps one read per cycle in flight.
    assign budget_ok = loop_q || (fetched < len_q);
    assign mem_rden  = run && budget_ok &&
                       (({1'b0, occ} + {2'b00, rd_vld_p1}) < (3'd2 + {2'b00, pop}));
    assign addr_wrap = loop_q && (({1'b0, mem_addr} + CNT_ONE) == len_q);

    // Stage p0 -> p1: control, fetch address and read-valid tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            len_q         <= '0;
            loop_q        <= 1'b0;
            gap_period_q  <= '0;
            gap_len_q     <= '0;
            full_period_q <= '0;
            full_len_q    <= '0;
            gap_phase     <= '0;
            full_phase    <= '0;
            fetched       <= '0;
            mem_addr      <= '0;
            rd_vld_p1     <= 1'b0;
            occ           <= '0;
            wr_ptr        <= 1'b0;
            rd_ptr        <= 1'b0;
            words_sent    <= '0;
            words_recv    <= '0;
            sink_checksum <= '0;
            err           <= '0;
        end else begin
            if (wr_acc) begin
                words_recv    <= words_recv + 32'd1;
                sink_checksum <= rotl_xor(sink_checksum, 32'(sink_fifo_data));
            end
            if (src_fifo_rden && src_fifo_empty) err[0] <= 1'b1;
            if (sink_fifo_wren && sink_fifo_full) err[1] <= 1'b1;

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        len_q         <= len;
                        loop_q        <= loop;
                        gap_period_q  <= gap_period;
                        gap_len_q     <= clamp_len(gap_period, gap_len);
                        full_period_q <= full_period;
                        full_len_q    <= clamp_len(full_period, full_len);
                        gap_phase     <= '0;
                        full_phase    <= '0;
                        fetched       <= '0;
                        mem_addr      <= '0;
                        rd_vld_p1     <= 1'b0;
                        occ           <= '0;
                        wr_ptr        <= 1'b0;
                        rd_ptr        <= 1'b0;
                        words_sent    <= '0;
                        words_recv    <= '0;
                        sink_checksum <= '0;
                        err           <= '0;
                        state         <= (len == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    gap_phase  <= next_phase(gap_phase, gap_period_q);
                    full_phase <= next_phase(full_phase, full_period_q);
                    if (mem_rden) begin
                        mem_addr <= addr_wrap ? '0 : mem_addr + ADDR_ONE;
                        if (!loop_q) fetched <= fetched + CNT_ONE;
                    end
                    rd_vld_p1 <= mem_rden;
                    if (rd_vld_p1) wr_ptr <= ~wr_ptr;
                    occ <= occ + {1'b0, rd_vld_p1} - {1'b0, pop};
                    if (pop) begin
                        rd_ptr     <= ~rd_ptr;
                        words_sent <= words_sent + 32'd1;
                    end
                    // Ending the run drops reads still in flight along with buffered words.
                    if (stop || (pop && !loop_q && (words_sent + 32'd1 == 32'(len_q)))) begin
                        state     <= DONE;
                        rd_vld_p1 <= 1'b0;
                        occ       <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stage p1 -> p2: returned memory word lands in the prefetch buffer
    always_ff @(posedge clk) begin
        if (rd_vld_p1) fifo_buf[wr_ptr] <= mem_data;
    end

endmodule

// File: tb/tb_stim_stream_driver.sv
// Bench for stim_stream_driver: per-cycle comparison against a word-level model plus directed literal checks.
module tb_stim_stream_driver;

    logic        clk = 1'b0;
    logic        rst, start, stop, loop;
    logic [15:0] len;
    logic [7:0]  gap_period, gap_len, full_period, full_len;
    logic        mem_rden;
    logic [14:0] mem_addr;
    logic [15:0] mem_data = '0;
    logic        src_fifo_empty, src_fifo_rden;
    logic [31:0] src_fifo_data;
    logic        sink_fifo_full, sink_fifo_wren;
    logic [31:0] sink_fifo_data;
    logic        busy, done;
    logic [31:0] words_sent, words_recv, sink_checksum;
    logic [1:0]  err;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    stim_stream_driver dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .len(len), .loop(loop),
        .gap_period(gap_period), .gap_len(gap_len), .full_period(full_period), .full_len(full_len),
        .mem_rden(mem_rden), .mem_addr(mem_addr), .mem_data(mem_data),
        .src_fifo_empty(src_fifo_empty), .src_fifo_rden(src_fifo_rden), .src_fifo_data(src_fifo_data),
        .sink_fifo_full(sink_fifo_full), .sink_fifo_wren(sink_fifo_wren), .sink_fifo_data(sink_fifo_data),
        .busy(busy), .done(done), .words_sent(words_sent), .words_recv(words_recv),
        .sink_checksum(sink_checksum), .err(err)
    );

    // Sample memory: each location holds its own address.
    always @(posedge clk) if (mem_rden) mem_data <= {1'b0, mem_addr};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit phase_hit(int c, int p, int l);
        int e;
        if (p == 0) return 1'b0;
        e = (l >= p) ? p - 1 : l;
        if (e == 0) return 1'b0;
        return (c % p) >= (p - e);
    endfunction

    // Word-level model: word k is fetched once word k-2 has been consumed,
    // and becomes visible two cycles after its fetch.
    bit          model_on = 1'b0;
    int          m_state = 0;  // 0 idle, 1 run, 2 done
    int          m_c = 0, m_sent = 0, m_ni = 0, m_len = 0;
    bit          m_loop = 1'b0;
    int          m_gp = 0, m_gl = 0, m_fp = 0, m_fl = 0;
    logic [31:0] m_recv = 0, m_csum = 0;
    logic [1:0]  m_err = 0;
    int          iq[$];
    bit          e_run, e_empty, e_pop, e_rden, e_full;
    int          e_addr, e_data;

    always @(negedge clk) begin
        if (model_on) begin
            e_run   = (m_state == 1);
            e_empty = !e_run || phase_hit(m_c, m_gp, m_gl) || !(iq.size() > 0 && iq[0] + 2 <= m_c);
            e_pop   = src_fifo_rden && !e_empty;
            e_rden  = e_run && (m_loop || m_ni < m_len) && (m_ni < m_sent + int'(e_pop) + 2);
            e_full  = e_run && phase_hit(m_c, m_fp, m_fl);
            e_addr  = (m_loop ? (m_ni % m_len) : m_ni) & 32'h7fff;
            e_data  = m_loop ? (m_sent % m_len) : m_sent;

            chk("empty", src_fifo_empty, e_empty);
            chk("mem_rden", mem_rden, e_rden);
            if (e_rden) chk("mem_addr", mem_addr, e_addr);
            if (!e_empty) chk("src_data", src_fifo_data, e_data);
            chk("sink_full", sink_fifo_full, e_full);
            chk("busy", busy, e_run);
            chk("done", done, m_state == 2);
            chk("words_sent", words_sent, m_sent);
            chk("words_recv", words_recv, m_recv);
            chk("checksum", sink_checksum, m_csum);
            chk("err", err, m_err);

            if (rst) begin
                m_state = 0; m_c = 0; m_sent = 0; m_ni = 0; m_recv = 0; m_csum = 0; m_err = 0;
                iq.delete();
            end else if (start && m_state != 1) begin
                m_len = int'(len); m_loop = loop;
                m_gp = gap_period; m_gl = gap_len; m_fp = full_period; m_fl = full_len;
                m_c = 0; m_sent = 0; m_ni = 0; m_recv = 0; m_csum = 0; m_err = 0;
                iq.delete();
                m_state = (m_len == 0) ? 2 : 1;
            end else begin
                if (sink_fifo_wren && !e_full) begin
                    m_recv++;
                    m_csum = ((m_csum << 1) | (m_csum >> 31)) ^ sink_fifo_data;
                end
                if (sink_fifo_wren && e_full) m_err[1] = 1'b1;
                if (src_fifo_rden && e_empty) m_err[0] = 1'b1;
                if (e_run) begin
                    if (e_rden) begin iq.push_back(m_c); m_ni++; end
                    if (e_pop) begin void'(iq.pop_front()); m_sent++; end
                    m_c++;
                    if (stop || (!m_loop && e_pop && m_sent == m_len)) begin
                        m_state = 2;
                        iq.delete();
                    end
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic kick(input int l, input bit lp, input int gp, input int gl, input int fp, input int fl);
        len = 16'(l); loop = lp;
        gap_period = 8'(gp); gap_len = 8'(gl); full_period = 8'(fp); full_len = 8'(fl);
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0; len = '0;
        gap_period = '0; gap_len = '0; full_period = '0; full_len = '0;
        src_fifo_rden = 1'b0; sink_fifo_wren = 1'b0; sink_fifo_data = '0;
        tick;
        model_on = 1'b1;
        tick;
        chk("rst_empty", src_fifo_empty, 1);
        chk("rst_rden", mem_rden, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sent", words_sent, 0);
        rst = 1'b0;
        tick;

        // Plain pass of 8 words at full rate.
        src_fifo_rden = 1'b1;
        kick(8, 0, 0, 0, 0, 0);
        chk("t1_busy", busy, 1);
        tick; tick;
        chk("t1_first_vis", src_fifo_empty, 0);
        chk("t1_word0", src_fifo_data, 0);
        tick;
        chk("t1_word1", src_fifo_data, 1);
        repeat (6) tick;
        chk("t1_not_done_e9", done, 0);
        tick;
        chk("t1_done_e10", done, 1);
        chk("t1_sent", words_sent, 8);
        src_fifo_rden = 1'b0;
        tick;

        // Periodic source gap on phase 7 of each 8-cycle period.
        src_fifo_rden = 1'b1;
        kick(16, 0, 8, 1, 0, 0);
        repeat (7) tick;
        chk("t2_gap_phase7", src_fifo_empty, 1);
        tick;
        chk("t2_after_gap", src_fifo_empty, 0);
        chk("t2_word5", src_fifo_data, 5);
        n = 0;
        while (!done && n < 40) begin tick; n++; end
        chk("t2_done", done, 1);
        chk("t2_cycles", n, 12);
        chk("t2_sent", words_sent, 16);
        src_fifo_rden = 1'b0;
        tick;

        // Loop mode, stop coincident with the 10th pop.
        src_fifo_rden = 1'b1;
        kick(4, 1, 0, 0, 0, 0);
        repeat (11) tick;
        chk("t3_pop10_data", src_fifo_data, 1);
        stop = 1'b1;
        tick;
        stop = 1'b0; src_fifo_rden = 1'b0;
        chk("t3_done", done, 1);
        chk("t3_sent", words_sent, 10);
        tick;

        // Sink back-pressure: full on phases 2,3 of every 4.
        kick(4, 1, 0, 0, 4, 2);
        for (int i = 0; i < 6; i++) begin
            chk("t4_full_pattern", sink_fifo_full, (i % 4) >= 2);
            sink_fifo_wren = 1'b1;
            sink_fifo_data = 32'((i % 3) + 1);
            tick;
        end
        sink_fifo_wren = 1'b0;
        chk("t4_recv", words_recv, 4);
        chk("t4_csum", sink_checksum, 7);
        chk("t4_err", err, 2);
        stop = 1'b1;
        tick;
        stop = 1'b0;

        // Zero-length start, then a pop while empty and a write in DONE.
        kick(0, 0, 0, 0, 0, 0);
        chk("t5_done", done, 1);
        chk("t5_busy", busy, 0);
        src_fifo_rden = 1'b1;
        tick;
        src_fifo_rden = 1'b0;
        chk("t5_err0", err, 1);
        chk("t5_data", src_fifo_data, 0);
        sink_fifo_wren = 1'b1; sink_fifo_data = 32'h9;
        tick;
        sink_fifo_wren = 1'b0;
        chk("t5_recv", words_recv, 1);
        chk("t5_csum", sink_checksum, 9);

        // Reset in the middle of a run.
        src_fifo_rden = 1'b1;
        kick(8, 1, 0, 0, 0, 0);
        repeat (5) tick;
        chk("t6_busy", busy, 1);
        rst = 1'b1;
        tick;
        chk("t6_busy", busy, 0);
        chk("t6_sent", words_sent, 0);
        chk("t6_recv", words_recv, 0);
        chk("t6_empty", src_fifo_empty, 1);
        chk("t6_rden", mem_rden, 0);
        chk("t6_err", err, 0);
        rst = 1'b0; src_fifo_rden = 1'b0;
        tick; tick;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
